// File: rtl/mem_cycle_ctrl_pkg.sv
// mem_cycle_ctrl_pkg: state encoding and timer sizing helpers shared by the SRAM cycle controller
package mem_cycle_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

    // A phase of n cycles loads n-1, so clog2(n) bits suffice; never narrower than 1 bit.
    function automatic int timer_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_cycle_ctrl_timer.sv
// mem_cycle_ctrl_timer: loadable down-counter that times each controller phase
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_load   load i_value this cycle (takes priority over counting)
//   i_value  reload value (phase length minus one)
//   o_zero   counter is at zero (final cycle of the phase)
//   o_one    counter is at one (next cycle is the final one)
module mem_cycle_ctrl_timer #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_zero,
    output logic         o_one
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_value;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - W'(1);
    end

    assign o_zero = (r_cnt == '0);
    assign o_one  = (r_cnt == W'(1));

endmodule

// File: rtl/mem_cycle_ctrl.sv
// mem_cycle_ctrl: async-SRAM read/write cycle controller with programmable setup/strobe/hold and bursts
//   i_clk, i_rst_n       clock (rising edge), asynchronous active-low reset
//   i_read, i_write      request levels; exactly one high starts a burst
//   i_addr_in            burst start address, sampled when a burst starts
//   i_wdata              write data, sampled on entry to each SETUP phase
//   i_sram_dq_in         data returned by the SRAM
//   o_sram_addr/o_sram_dq  SRAM address and write data
//   o_de, o_nwe, o_noe   bus drive enable, write strobe (low), output enable (low)
//   o_latch, o_count     burst-start pulse, last-HOLD pulse (address advances)
//   o_writing/o_reading  burst in progress flags
//   o_rdata              captured read data
//   o_done, o_err        beat-complete pulse, conflicting-request pulse
module mem_cycle_ctrl
    import mem_cycle_ctrl_pkg::*;
#(
    parameter int AW        = 16,
    parameter int DW        = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC  = 1,
    parameter int BURST_MAX = 0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_read,
    input  logic          i_write,
    input  logic [AW-1:0] i_addr_in,
    input  logic [DW-1:0] i_wdata,
    input  logic [DW-1:0] i_sram_dq_in,
    output logic [AW-1:0] o_sram_addr,
    output logic [DW-1:0] o_sram_dq,
    output logic          o_de,
    output logic          o_nwe,
    output logic          o_noe,
    output logic          o_latch,
    output logic          o_count,
    output logic          o_writing,
    output logic          o_reading,
    output logic [DW-1:0] o_rdata,
    output logic          o_done,
    output logic          o_err
);

    if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_cyc
        $error("mem_cycle_ctrl: SETUP_CYC, PULSE_CYC and HOLD_CYC must all be >= 1");
    end

    localparam int TW = timer_width(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC));
    localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYC - 1);
    localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYC - 1);

    state_t        r_state;
    logic [31:0]   r_beats;
    logic [AW-1:0] r_sram_addr;
    logic [DW-1:0] r_sram_dq;
    logic [DW-1:0] r_rdata;
    logic          r_de;
    logic          r_nwe;
    logic          r_noe;
    logic          r_latch;
    logic          r_count;
    logic          r_writing;
    logic          r_reading;
    logic          r_done;
    logic          r_err;

    logic          w_req_one;
    logic          w_more;
    logic          w_load;
    logic [TW-1:0] w_load_val;
    logic          w_zero;
    logic          w_one;

    assign w_req_one  = i_read ^ i_write;
    // Same mode still requested, other mode quiet, and the beat limit not yet reached.
    assign w_more     = (r_writing ? (i_write & ~i_read) : (i_read & ~i_write)) &
                        ((BURST_MAX == 0) || (r_beats < 32'(BURST_MAX)));
    assign w_load     = (r_state == S_IDLE) ? w_req_one : w_zero;
    // A HOLD exit always loads the SETUP length; if the burst ends the idle timer is simply ignored.
    assign w_load_val = (r_state == S_SETUP) ? PULSE_LD :
                        (r_state == S_PULSE) ? HOLD_LD  : SETUP_LD;

    mem_cycle_ctrl_timer #(.W(TW)) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_load),
        .i_value (w_load_val),
        .o_zero  (w_zero),
        .o_one   (w_one)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_beats     <= '0;
            r_sram_addr <= '0;
            r_sram_dq   <= '0;
            r_rdata     <= '0;
            r_de        <= 1'b0;
            r_nwe       <= 1'b1;
            r_noe       <= 1'b1;
            r_latch     <= 1'b0;
            r_count     <= 1'b0;
            r_writing   <= 1'b0;
            r_reading   <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_latch <= 1'b0;
            r_count <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_err <= i_read & i_write;
                    if (w_req_one) begin
                        r_state     <= S_SETUP;
                        r_sram_addr <= i_addr_in;
                        r_sram_dq   <= i_wdata;
                        r_writing   <= i_write;
                        r_reading   <= i_read;
                        r_de        <= i_write;
                        r_latch     <= 1'b1;
                        r_beats     <= 32'd1;
                    end
                end
                S_SETUP: begin
                    if (w_zero) begin
                        r_state <= S_PULSE;
                        r_nwe   <= ~r_writing;
                        r_noe   <= ~r_reading;
                    end
                end
                S_PULSE: begin
                    if (w_zero) begin
                        r_state <= S_HOLD;
                        r_nwe   <= 1'b1;
                        r_noe   <= 1'b1;
                        r_count <= (HOLD_CYC == 1);
                        if (r_reading)
                            r_rdata <= i_sram_dq_in;
                    end
                end
                S_HOLD: begin
                    if (w_zero) begin
                        r_sram_addr <= r_sram_addr + AW'(1);
                        r_done      <= 1'b1;
                        if (w_more) begin
                            r_state   <= S_SETUP;
                            r_sram_dq <= i_wdata;
                            r_beats   <= r_beats + 32'd1;
                        end else begin
                            r_state   <= S_IDLE;
                            r_de      <= 1'b0;
                            r_writing <= 1'b0;
                            r_reading <= 1'b0;
                        end
                    end else begin
                        // count is registered, so raise it one cycle ahead of the final HOLD cycle
                        r_count <= w_one;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_sram_addr = r_sram_addr;
    assign o_sram_dq   = r_sram_dq;
    assign o_de        = r_de;
    assign o_nwe       = r_nwe;
    assign o_noe       = r_noe;
    assign o_latch     = r_latch;
    assign o_count     = r_count;
    assign o_writing   = r_writing;
    assign o_reading   = r_reading;
    assign o_rdata     = r_rdata;
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule

// File: tb/tb_mem_cycle_ctrl.sv
// tb_mem_cycle_ctrl: directed self-checking bench for mem_cycle_ctrl
module tb_mem_cycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        a_read = 1'b0;
    logic        a_write = 1'b0;
    logic        b_read = 1'b0;
    logic        b_write = 1'b0;
    logic [15:0] addr_in = '0;
    logic [7:0]  wdata = '0;

    logic [15:0] a_sram_addr, b_sram_addr;
    logic [7:0]  a_sram_dq, b_sram_dq, a_rdata, b_rdata, a_dq_in;
    logic        a_de, a_nwe, a_noe, a_latch, a_count, a_writing, a_reading, a_done, a_err;
    logic        b_de, b_nwe, b_noe, b_latch, b_count, b_writing, b_reading, b_done, b_err;

    int n_tests = 0;
    int n_fail  = 0;

    // SRAM model for reads: returns the low address byte
    assign a_dq_in = a_sram_addr[7:0];

    always #5 clk = ~clk;

    mem_cycle_ctrl #(.BURST_MAX(4)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_read(a_read), .i_write(a_write),
        .i_addr_in(addr_in), .i_wdata(wdata), .i_sram_dq_in(a_dq_in),
        .o_sram_addr(a_sram_addr), .o_sram_dq(a_sram_dq), .o_de(a_de), .o_nwe(a_nwe),
        .o_noe(a_noe), .o_latch(a_latch), .o_count(a_count), .o_writing(a_writing),
        .o_reading(a_reading), .o_rdata(a_rdata), .o_done(a_done), .o_err(a_err)
    );

    mem_cycle_ctrl #(.SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(1)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_read(b_read), .i_write(b_write),
        .i_addr_in(addr_in), .i_wdata(wdata), .i_sram_dq_in(8'h3C),
        .o_sram_addr(b_sram_addr), .o_sram_dq(b_sram_dq), .o_de(b_de), .o_nwe(b_nwe),
        .o_noe(b_noe), .o_latch(b_latch), .o_count(b_count), .o_writing(b_writing),
        .o_reading(b_reading), .o_rdata(b_rdata), .o_done(b_done), .o_err(b_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_nwe", a_nwe, 1);
        check("rst_noe", a_noe, 1);
        check("rst_de", a_de, 0);
        check("rst_addr", a_sram_addr, 0);
        check("rst_rdata", a_rdata, 0);
        check("rst_done", a_done, 0);
        check("rst_b_addr", b_sram_addr, 0);
        check("rst_b_dq", b_sram_dq, 0);
        check("rst_b_rdata", b_rdata, 0);
        check("rst_b_flags", {b_noe, b_latch, b_reading, b_err}, 4'b1000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: single write beat
        a_write = 1'b1; addr_in = 16'h0010; wdata = 8'hA5;
        tick();
        a_write = 1'b0;
        check("w1_latch", a_latch, 1);
        check("w1_addr", a_sram_addr, 16'h0010);
        check("w1_dq", a_sram_dq, 8'hA5);
        check("w1_de_setup", a_de, 1);
        check("w1_nwe_setup", a_nwe, 1);
        check("w1_writing", a_writing, 1);
        tick();
        check("w1_nwe_pulse", a_nwe, 0);
        check("w1_noe_pulse", a_noe, 1);
        check("w1_latch_off", a_latch, 0);
        tick();
        check("w1_count", a_count, 1);
        check("w1_nwe_hold", a_nwe, 1);
        check("w1_de_hold", a_de, 1);
        tick();
        check("w1_done", a_done, 1);
        check("w1_addr_next", a_sram_addr, 16'h0011);
        check("w1_idle", {a_writing, a_de, a_count}, 0);
        tick();
        check("w1_done_off", a_done, 0);

        // 2: read burst limited to 4 beats
        a_read = 1'b1; addr_in = 16'h0010;
        tick();
        for (int b = 0; b < 4; b++) begin
            check("r2_addr", a_sram_addr, 32'h10 + b);
            check("r2_latch", a_latch, (b == 0) ? 1 : 0);
            check("r2_done", a_done, (b == 0) ? 0 : 1);
            check("r2_reading", a_reading, 1);
            tick();
            check("r2_noe", a_noe, 0);
            check("r2_de", a_de, 0);
            tick();
            check("r2_rdata", a_rdata, 32'h10 + b);
            check("r2_count", a_count, 1);
            tick();
        end
        check("r2_done_last", a_done, 1);
        check("r2_idle", {a_reading, a_noe}, 2'b01);
        a_read = 1'b0;
        tick();
        check("r2_stay_idle", {a_reading, a_latch, a_done}, 0);

        // 3: SETUP=2, PULSE=3, HOLD=1 two-beat write on dut_b
        b_write = 1'b1; addr_in = 16'h0040; wdata = 8'h77;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check("s3_de", b_de, 1);
            check("s3_nwe", b_nwe, ((i - 1) % 6 >= 2 && (i - 1) % 6 <= 4) ? 0 : 1);
            check("s3_count", b_count, ((i - 1) % 6 == 5) ? 1 : 0);
            check("s3_done", b_done, (i == 7) ? 1 : 0);
            check("s3_writing", b_writing, 1);
            if (i == 7) b_write = 1'b0;
        end
        tick();
        check("s3_done_end", b_done, 1);
        check("s3_de_end", b_de, 0);
        check("s3_addr_end", b_sram_addr, 16'h0042);

        // 4: conflicting requests in IDLE
        a_read = 1'b1; a_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("c4_err", a_err, 1);
            check("c4_quiet", {a_nwe, a_noe, a_de, a_latch, a_writing, a_reading, a_done}, 7'b1100000);
        end
        a_read = 1'b0; a_write = 1'b0;
        tick();
        check("c4_err_off", a_err, 0);

        // 5: async reset mid-PULSE of a write
        a_write = 1'b1; addr_in = 16'h0020; wdata = 8'h5A;
        tick();
        a_write = 1'b0;
        tick();
        check("a5_nwe_pulse", a_nwe, 0);
        #2 rst_n = 1'b0;
        #1;
        check("a5_nwe_rst", a_nwe, 1);
        check("a5_de_rst", a_de, 0);
        check("a5_addr_rst", a_sram_addr, 0);
        tick();
        check("a5_no_done", a_done, 0);
        rst_n = 1'b1;
        a_write = 1'b1; addr_in = 16'h0030; wdata = 8'hC3;
        tick();
        a_write = 1'b0;
        check("a5_restart_latch", a_latch, 1);
        check("a5_restart_addr", a_sram_addr, 16'h0030);
        check("a5_restart_nwe", a_nwe, 1);
        tick();
        check("a5_restart_pulse", a_nwe, 0);
        tick();
        tick();
        check("a5_restart_done", a_done, 1);

        // 6: address wrap across a 2-beat write burst
        a_write = 1'b1; addr_in = 16'hFFFF; wdata = 8'h11;
        tick();
        check("w6_addr0", a_sram_addr, 16'hFFFF);
        check("w6_dq0", a_sram_dq, 8'h11);
        tick();
        tick();
        wdata = 8'h22;
        tick();
        a_write = 1'b0;
        check("w6_addr1", a_sram_addr, 16'h0000);
        check("w6_dq1", a_sram_dq, 8'h22);
        check("w6_done0", a_done, 1);
        check("w6_no_latch", a_latch, 0);
        tick();
        tick();
        tick();
        check("w6_done1", a_done, 1);
        check("w6_addr_final", a_sram_addr, 16'h0001);
        check("w6_idle", a_writing, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
